// File: rtl/adc_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_avg_pkg
// Purpose  : Shared constants, FSM state encoding and arithmetic helpers for
//            the ADC decimating averager (adc_decim_avg / adc_round_shift).
// Contents : c_w_aio / c_k_max / c_w_acc  default sample width, largest
//                                          decimation exponent, accumulator
//                                          width derived from the two
//            avg_state_t                   IDLE / ACCUM / DUMP
//            clamp_k()                     limit a requested exponent
//            round_sat()                   round-half-up arithmetic shift
//                                          with saturation to a signed width
// Revision : 1.0  initial release
// ============================================================================
package adc_avg_pkg;

   localparam int unsigned c_w_aio = 16;
   localparam int unsigned c_k_max = 8;
   // Headroom for 2^K_MAX full-scale samples, so the running sum cannot wrap.
   localparam int unsigned c_w_acc = c_w_aio + c_k_max;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DUMP  = 2'd2
   } avg_state_t;

   // Exponents above k_max are treated as k_max.
   function automatic logic [3:0] clamp_k(input logic [3:0] k,
                                          input int unsigned k_max);
      clamp_k = (32'(k) > k_max) ? 4'(k_max) : k;
   endfunction

   // (acc + 2^(k-1)) >>> k, or acc itself for k = 0, then clamped to the
   // signed range of w_out bits. Computed in 64 bits so that the rounding
   // bias can never overflow for any accumulator width used here.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                    input logic [3:0]         k,
                                                    input int unsigned        w_out);
      logic signed [63:0] v_bias;
      logic signed [63:0] v_q;
      logic signed [63:0] v_max;
      logic signed [63:0] v_min;
      v_bias = (k == 4'd0) ? 64'sd0 : (64'sd1 <<< (k - 4'd1));
      v_q    = (acc + v_bias) >>> k;
      v_max  = (64'sd1 <<< (w_out - 32'd1)) - 64'sd1;
      v_min  = -(64'sd1 <<< (w_out - 32'd1));
      if (v_q > v_max) begin
         round_sat = v_max;
      end else if (v_q < v_min) begin
         round_sat = v_min;
      end else begin
         round_sat = v_q;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/adc_round_shift.sv
`default_nettype none
// ============================================================================
// Module   : adc_round_shift
// Purpose  : Combinational window-mean divider: rounds the accumulated sum
//            half-up, shifts right arithmetically by k and saturates the
//            result into a W_AIO-bit signed sample.
// Ports    : i_acc  [W_ACC-1:0] signed window sum
//            i_k    [3:0]       latched decimation exponent
//            o_avg  [W_AIO-1:0] signed rounded mean
// Revision : 1.0  initial release
// ============================================================================
module adc_round_shift
   import adc_avg_pkg::*;
#(
   parameter int unsigned W_AIO = c_w_aio,
   parameter int unsigned W_ACC = c_w_acc
)(
   input  logic signed [W_ACC-1:0] i_acc,
   input  logic        [3:0]       i_k,
   output logic signed [W_AIO-1:0] o_avg
);

   logic signed [63:0] w_acc_ext;
   logic signed [63:0] w_q;
   logic               w_unused_hi;

   assign w_acc_ext = {{(64 - W_ACC){i_acc[W_ACC-1]}}, i_acc};
   assign w_q       = round_sat(w_acc_ext, i_k, W_AIO);

   // After saturation the upper bits are pure sign copies of bit W_AIO-1.
   assign o_avg       = w_q[W_AIO-1:0];
   assign w_unused_hi = ^w_q[63:W_AIO];

endmodule
`default_nettype wire

// File: rtl/adc_decim_avg.sv
`default_nettype none
// ============================================================================
// Module   : adc_decim_avg
// Purpose  : Accumulates 2^k consecutive signed ADC samples and emits their
//            rounded mean with a one-cycle valid strobe. k is latched at
//            each window start; back-to-back strobes lose no samples.
// Ports    : clk      system clock
//            rst_n    synchronous reset, active-low
//            smp_in   [W_AIO-1:0] signed sample from ADC capture register
//            smp_stb  new-sample strobe
//            en       averaging enable (checked at window boundaries)
//            dec_k    [3:0] decimation exponent, clamped to K_MAX
//            avg_out  [W_AIO-1:0] signed rounded window mean
//            avg_vld  one-cycle strobe, avg_out updated
//            reg_avg  [W_REG-1:0] avg_out sign-extended for readback
//            win_cnt  [15:0] completed-window counter (wraps)
//            min_out / max_out [W_AIO-1:0] signed per-window extremes,
//                     present only when ADC_AVG_MINMAX_EN is defined
// Revision : 1.0  initial release
// ============================================================================
module adc_decim_avg
   import adc_avg_pkg::*;
#(
   parameter int unsigned W_AIO = c_w_aio,
   parameter int unsigned W_REG = 32,
   parameter int unsigned K_MAX = c_k_max
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [W_AIO-1:0] smp_in,
   input  logic                    smp_stb,
   input  logic                    en,
   input  logic        [3:0]       dec_k,
   output logic signed [W_AIO-1:0] avg_out,
   output logic                    avg_vld,
   output logic signed [W_REG-1:0] reg_avg,
   output logic        [15:0]      win_cnt
`ifdef ADC_AVG_MINMAX_EN
   ,
   output logic signed [W_AIO-1:0] min_out,
   output logic signed [W_AIO-1:0] max_out
`endif
);

   localparam int unsigned W_ACC   = W_AIO + K_MAX;
   // One extra bit so the counter can hold 2^K_MAX itself.
   localparam int unsigned c_w_cnt = K_MAX + 1;

   avg_state_t                 r_state;
   avg_state_t                 w_state_nxt;
   logic signed [W_ACC-1:0]    r_acc;
   logic signed [W_ACC-1:0]    w_acc_nxt;
   logic        [c_w_cnt-1:0]  r_cnt;
   logic        [c_w_cnt-1:0]  w_cnt_nxt;
   logic        [3:0]          r_k_lat;
   logic        [3:0]          w_k_nxt;
   logic                       w_dump;

   logic signed [W_ACC-1:0]    w_smp_ext;
   logic        [3:0]          w_k_in;
   logic        [c_w_cnt-1:0]  w_win_lat;
   logic        [c_w_cnt-1:0]  w_win_in;
   logic signed [W_AIO-1:0]    w_rnd;

   logic signed [W_AIO-1:0]    r_avg_out;
   logic                       r_avg_vld;
   logic        [15:0]         r_win_cnt;

   assign w_smp_ext = {{K_MAX{smp_in[W_AIO-1]}}, smp_in};
   assign w_k_in    = clamp_k(dec_k, K_MAX);
   assign w_win_lat = c_w_cnt'(1) << r_k_lat;
   assign w_win_in  = c_w_cnt'(1) << w_k_in;

   // ------------------------------------------------------------------------
   // Window FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_k_nxt     = r_k_lat;
      w_dump      = 1'b0;
      case (r_state)
         IDLE: begin
            // A strobe coinciding with the start transition is not counted.
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
            if (en) begin
               w_k_nxt     = w_k_in;
               w_state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (smp_stb) begin
               w_acc_nxt = r_acc + w_smp_ext;
               w_cnt_nxt = r_cnt + c_w_cnt'(1);
               if ((r_cnt + c_w_cnt'(1)) == w_win_lat) begin
                  w_state_nxt = DUMP;
               end
            end
         end
         DUMP: begin
            w_dump    = 1'b1;
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
            if (en) begin
               w_k_nxt     = w_k_in;
               w_state_nxt = ACCUM;
               // Strobe during the dump cycle opens the next window; with
               // k = 0 that single sample already completes it.
               if (smp_stb) begin
                  w_acc_nxt = w_smp_ext;
                  w_cnt_nxt = c_w_cnt'(1);
                  if (w_win_in == c_w_cnt'(1)) begin
                     w_state_nxt = DUMP;
                  end
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Rounding divider on the held window sum
   // ------------------------------------------------------------------------
   adc_round_shift #(
      .W_AIO (W_AIO),
      .W_ACC (W_ACC)
   ) u_round_shift (
      .i_acc (r_acc),
      .i_k   (r_k_lat),
      .o_avg (w_rnd)
   );

   // ------------------------------------------------------------------------
   // Datapath and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_k_lat   <= '0;
         r_avg_out <= '0;
         r_avg_vld <= 1'b0;
         r_win_cnt <= '0;
      end else begin
         r_acc     <= w_acc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_k_lat   <= w_k_nxt;
         r_avg_vld <= w_dump;
         if (w_dump) begin
            r_avg_out <= w_rnd;
            r_win_cnt <= r_win_cnt + 16'd1;
         end
      end
   end

   assign avg_out = r_avg_out;
   assign avg_vld = r_avg_vld;
   assign reg_avg = {{(W_REG - W_AIO){r_avg_out[W_AIO-1]}}, r_avg_out};
   assign win_cnt = r_win_cnt;

`ifdef ADC_AVG_MINMAX_EN
   // ------------------------------------------------------------------------
   // Per-window extremes, restarted by the first sample of every window
   // ------------------------------------------------------------------------
   logic                    w_take;
   logic                    w_first;
   logic signed [W_AIO-1:0] r_min;
   logic signed [W_AIO-1:0] r_max;
   logic signed [W_AIO-1:0] r_min_out;
   logic signed [W_AIO-1:0] r_max_out;

   assign w_take  = smp_stb && ((r_state == ACCUM) || ((r_state == DUMP) && en));
   assign w_first = (r_state == DUMP) || (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_min     <= '0;
         r_max     <= '0;
         r_min_out <= '0;
         r_max_out <= '0;
      end else begin
         if (w_take) begin
            if (w_first || (smp_in < r_min)) begin
               r_min <= smp_in;
            end
            if (w_first || (smp_in > r_max)) begin
               r_max <= smp_in;
            end
         end
         if (w_dump) begin
            r_min_out <= r_min;
            r_max_out <= r_max;
         end
      end
   end

   assign min_out = r_min_out;
   assign max_out = r_max_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_decim_avg.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_decim_avg
// Purpose  : Self-checking bench for adc_decim_avg. A behavioural window
//            model queues the expected mean, window count and output cycle
//            whenever a window completes; a monitor compares on avg_vld.
//            Min/max outputs are checked when ADC_AVG_MINMAX_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_decim_avg;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic [15:0] smp_in  = '0;
   logic        smp_stb = 1'b0;
   logic        en      = 1'b0;
   logic [3:0]  dec_k   = '0;
   logic [15:0] avg_out;
   logic        avg_vld;
   logic [31:0] reg_avg;
   logic [15:0] win_cnt;
`ifdef ADC_AVG_MINMAX_EN
   logic [15:0] min_out;
   logic [15:0] max_out;
`endif

   adc_decim_avg u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .smp_in  (smp_in),
      .smp_stb (smp_stb),
      .en      (en),
      .dec_k   (dec_k),
      .avg_out (avg_out),
      .avg_vld (avg_vld),
      .reg_avg (reg_avg),
`ifdef ADC_AVG_MINMAX_EN
      .min_out (min_out),
      .max_out (max_out),
`endif
      .win_cnt (win_cnt)
   );

   always #5 clk = ~clk;

   int r_cyc = 0;
   always @(posedge clk) r_cyc <= r_cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp_v, r_cyc);
      end
   endtask

   // ------------------------------------------------------------------------
   // Window model and scoreboard
   // ------------------------------------------------------------------------
   typedef struct {
      logic [15:0] avg;
      logic [15:0] mn;
      logic [15:0] mx;
      logic [15:0] win;
      int          cyc;
   } exp_t;

   exp_t               sb_q[$];
   longint             m_sum    = 0;
   int                 m_n      = 0;
   int                 m_k      = 0;
   bit                 m_active = 1'b0;
   bit                 m_latch  = 1'b0;
   logic [15:0]        m_win    = '0;
   logic signed [15:0] m_min    = '0;
   logic signed [15:0] m_max    = '0;
   bit                 tb_en    = 1'b0;
   logic [3:0]         tb_k     = '0;

   function automatic int clampk(input logic [3:0] k);
      return (k > 4'd8) ? 8 : int'(k);
   endfunction

   function automatic logic [15:0] exp_avg(input longint sum, input int k);
      longint b;
      longint q;
      b = (k == 0) ? 64'sd0 : (longint'(1) << (k - 1));
      q = (sum + b) >>> k;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return q[15:0];
   endfunction

   // One clock of stimulus; en/dec_k come from tb_en/tb_k.
   task automatic tick(input bit stb, input logic signed [15:0] val);
      bit take;
      @(negedge clk);
      rst_n   = 1'b1;
      en      = tb_en;
      dec_k   = tb_k;
      smp_stb = stb;
      smp_in  = val;
      take    = 1'b0;
      if (m_latch) begin
         m_latch = 1'b0;
         if (tb_en) begin
            m_k  = clampk(tb_k);
            take = stb;
         end else begin
            m_active = 1'b0;
         end
      end else if (!m_active) begin
         if (tb_en) begin
            m_k      = clampk(tb_k);
            m_active = 1'b1;
         end
      end else begin
         take = stb;
      end
      if (take) begin
         if (m_n == 0) begin
            m_min = val;
            m_max = val;
         end else begin
            if (val < m_min) m_min = val;
            if (val > m_max) m_max = val;
         end
         m_sum += val;
         m_n++;
         if (m_n == (1 << m_k)) begin
            m_win = m_win + 16'd1;
            sb_q.push_back('{avg: exp_avg(m_sum, m_k), mn: m_min, mx: m_max,
                             win: m_win, cyc: r_cyc + 2});
            m_sum   = 0;
            m_n     = 0;
            m_latch = 1'b1;
         end
      end
   endtask

   task automatic do_reset(input int n);
      repeat (n) begin
         @(negedge clk);
         rst_n   = 1'b0;
         smp_stb = 1'b0;
         en      = tb_en;
         dec_k   = tb_k;
      end
      m_sum    = 0;
      m_n      = 0;
      m_active = 1'b0;
      m_latch  = 1'b0;
      m_win    = '0;
      sb_q.delete();
   endtask

   // ------------------------------------------------------------------------
   // Output monitor
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      if (avg_vld === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("spurious_vld", 32'd1, 32'd0);
         end else begin : b_pop
            exp_t e;
            e = sb_q.pop_front();
            chk("avg_out", {16'd0, avg_out}, {16'd0, e.avg});
            chk("reg_avg", reg_avg, {{16{e.avg[15]}}, e.avg});
            chk("win_cnt", {16'd0, win_cnt}, {16'd0, e.win});
            chk("latency", r_cyc, e.cyc);
`ifdef ADC_AVG_MINMAX_EN
            chk("min_out", {16'd0, min_out}, {16'd0, e.mn});
            chk("max_out", {16'd0, max_out}, {16'd0, e.mx});
`endif
         end
      end else if (sb_q.size() != 0 && sb_q[0].cyc < r_cyc) begin
         chk("vld_missing", 32'd0, 32'd1);
         void'(sb_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   int s_a[4] = '{10, 11, 12, 14};
   int s_b[4] = '{20, 21, 22, 23};
   logic [15:0] r_rand;

   initial begin
      do_reset(3);
      tick(1'b0, 16'sd0);
      chk("rst_avg_out", {16'd0, avg_out}, 32'd0);
      chk("rst_avg_vld", {31'd0, avg_vld}, 32'd0);
      chk("rst_reg_avg", reg_avg, 32'd0);
      chk("rst_win_cnt", {16'd0, win_cnt}, 32'd0);
`ifdef ADC_AVG_MINMAX_EN
      chk("rst_min_out", {16'd0, min_out}, 32'd0);
      chk("rst_max_out", {16'd0, max_out}, 32'd0);
`endif

      // k=2: strobe on the start cycle is ignored, mean of 10,11,12,14 = 12
      tb_k  = 4'd2;
      tb_en = 1'b1;
      tick(1'b1, 16'sd1000);
      for (int i = 0; i < 4; i++) tick(1'b1, 16'(s_a[i]));

      // k=1 relatched in the dump cycle; -3 arrives during that cycle
      tb_k = 4'd1;
      tick(1'b1, -16'sd3);
      tick(1'b1, -16'sd4);

      // k=0: every strobe is a window, back to back
      tb_k = 4'd0;
      tick(1'b1, 16'sd5);
      tick(1'b1, -16'sd1);
      tick(1'b1, 16'sd7);

      // k=8 full-scale windows
      tb_k = 4'd8;
      repeat (256) tick(1'b1, 16'sh7FFF);
      repeat (256) tick(1'b1, 16'sh8000);

      // dec_k 2->3 mid-window: this window stays at 4, the next is 8
      tb_k = 4'd2;
      tick(1'b1, 16'sd3);
      tick(1'b1, -16'sd9);
      tb_k = 4'd3;
      tick(1'b1, 16'sd100);
      tick(1'b1, -16'sd50);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) tb_k = 4'd15;
         r_rand = 16'($urandom);
         tick(1'b1, r_rand);
      end

      // dec_k=15 clamps to 8
      for (int i = 0; i < 256; i++) begin
         r_rand = 16'($urandom);
         tick(1'b1, r_rand);
      end

      // en low at the boundary: dump-cycle strobe dropped, block idles
      tb_en = 1'b0;
      tick(1'b1, 16'sd5000);
      tick(1'b1, 16'sd1);
      tick(1'b0, 16'sd0);

      // reset mid-window with en held high
      tb_k  = 4'd2;
      tb_en = 1'b1;
      tick(1'b0, 16'sd0);
      tick(1'b1, 16'sd100);
      tick(1'b1, 16'sd200);
      do_reset(1);
      tick(1'b0, 16'sd0);
      chk("midrst_win_cnt", {16'd0, win_cnt}, 32'd0);
      chk("midrst_avg_out", {16'd0, avg_out}, 32'd0);
      for (int i = 0; i < 4; i++) tick(1'b1, 16'(s_b[i]));

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick(1'b0, 16'sd0);
      tick(1'b0, 16'sd0);
      chk("drain_empty", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
